// File: rtl/step_counter.sv
// step_counter: programmable up/down counter stepped by rising edges of
// the scaled inc_clk level, with wrap, saturate, bounce and hold modes
// against a runtime inclusive limit and a one-cycle terminal-count pulse.
module step_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_clk,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             dir_out
);

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_e            mode_sel;
  logic             step;

  logic             inc_r_q, inc_r_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             bdir_q, bdir_d;
  logic             dir_out_q, dir_out_d;

  assign mode_sel = mode_e'(mode);
  assign step     = inc_clk & ~inc_r_q;

  // Next-state: load beats step; a step outside the valid range is pulled
  // back in first, limit==0 pins the count at zero, then the per-mode rules.
  always_comb begin
    inc_r_d   = inc_clk;
    count_d   = count_q;
    tc_d      = 1'b0;
    bdir_d    = bdir_q;
    if (load) begin
      count_d = (load_val > limit) ? limit : load_val;
      bdir_d  = 1'b0;
    end else if (step && (mode_sel != MODE_HOLD)) begin
      if (count_q > limit) begin
        count_d = (mode_sel == MODE_WRAP) ? '0 : limit;
        tc_d    = 1'b1;
      end else if (limit == '0) begin
        count_d = '0;
        tc_d    = 1'b1;
      end else begin
        case (mode_sel)
          MODE_WRAP: begin
            if (dir) begin
              if (count_q == '0) begin
                count_d = limit;
                tc_d    = 1'b1;
              end else begin
                count_d = count_q - ONE;
              end
            end else begin
              if (count_q == limit) begin
                count_d = '0;
                tc_d    = 1'b1;
              end else begin
                count_d = count_q + ONE;
              end
            end
          end
          MODE_SAT: begin
            if (dir) begin
              if (count_q == '0) tc_d = 1'b1;
              else               count_d = count_q - ONE;
            end else begin
              if (count_q == limit) tc_d = 1'b1;
              else                  count_d = count_q + ONE;
            end
          end
          MODE_BOUNCE: begin
            if (bdir_q) begin
              if (count_q == '0) begin
                count_d = count_q + ONE;
                bdir_d  = 1'b0;
                tc_d    = 1'b1;
              end else begin
                count_d = count_q - ONE;
              end
            end else begin
              if (count_q == limit) begin
                count_d = count_q - ONE;
                bdir_d  = 1'b1;
                tc_d    = 1'b1;
              end else begin
                count_d = count_q + ONE;
              end
            end
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end
    end
    dir_out_d = (mode_sel == MODE_BOUNCE) ? bdir_d : dir;
  end

  // State registers; the edge register resets high so a level already
  // present at reset release is not mistaken for a new step.
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_r_q   <= 1'b1;
      count_q   <= '0;
      tc_q      <= 1'b0;
      bdir_q    <= 1'b0;
      dir_out_q <= 1'b0;
    end else begin
      inc_r_q   <= inc_r_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
      bdir_q    <= bdir_d;
      dir_out_q <= dir_out_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign dir_out = dir_out_q;

endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: directed table of step vectors, hand-written reset
// sequences, then randomized traffic checked against a behavioural model.
module tb_step_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       inc_clk;
  logic       dir;
  logic [1:0] mode;
  logic [7:0] limit;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc;
  logic       dir_out;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state kept in plain integers.
  int mCount;
  int mBounceDown;
  int mPrevInc;
  int mTc;
  int mDirOut;

  typedef struct {
    string      name;
    bit         rst;
    bit         dir;
    bit [1:0]   mode;
    bit [7:0]   limit;
    bit         load;
    bit [7:0]   loadVal;
    bit [7:0]   eCount;
    bit         eTc;
    bit         eDir;
  } vec_t;

  vec_t vecs[$];

  step_counter #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .inc_clk  (inc_clk),
    .dir      (dir),
    .mode     (mode),
    .limit    (limit),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .dir_out  (dir_out)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelUpdate();
    int step, delta, nxt, lim;
    lim = int'(limit);
    if (reset) begin
      mCount = 0; mTc = 0; mDirOut = 0; mBounceDown = 0; mPrevInc = 1;
      return;
    end
    step = (inc_clk && !mPrevInc) ? 1 : 0;
    mPrevInc = inc_clk;
    mTc = 0;
    if (load) begin
      mCount = (int'(load_val) < lim) ? int'(load_val) : lim;
      mBounceDown = 0;
    end else if (step == 1 && mode != 2'b11) begin
      if (mCount > lim) begin
        mCount = (mode == 2'b00) ? 0 : lim;
        mTc = 1;
      end else if (lim == 0) begin
        mCount = 0;
        mTc = 1;
      end else begin
        if (mode == 2'b10) delta = mBounceDown ? -1 : 1;
        else               delta = dir ? -1 : 1;
        nxt = mCount + delta;
        if (nxt >= 0 && nxt <= lim) begin
          mCount = nxt;
        end else begin
          mTc = 1;
          case (mode)
            2'b00: mCount = (nxt < 0) ? lim : 0;
            2'b10: begin
              mCount = mCount - delta;
              mBounceDown = 1 - mBounceDown;
            end
            default: ;
          endcase
        end
      end
    end
    mDirOut = (mode == 2'b10) ? mBounceDown : int'(dir);
  endtask

  task automatic tick();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eCount,
                             input logic eTc, input logic eDir);
    nChecks++;
    if (count !== eCount || tc !== eTc || dir_out !== eDir) begin
      nErrors++;
      $display("[TB] FAIL %s: got count=%0d tc=%0b dir_out=%0b, want count=%0d tc=%0b dir_out=%0b",
               name, count, tc, dir_out, eCount, eTc, eDir);
    end
  endtask

  task automatic addVec(input string name, input bit d, input bit [1:0] m,
                        input bit [7:0] lim, input bit ld, input bit [7:0] lv,
                        input bit [7:0] ec, input bit et, input bit ed);
    vec_t v;
    v.name = name; v.rst = 1'b0; v.dir = d; v.mode = m; v.limit = lim;
    v.load = ld; v.loadVal = lv; v.eCount = ec; v.eTc = et; v.eDir = ed;
    vecs.push_back(v);
  endtask

  task automatic addReset(input string name);
    vec_t v;
    v = '{name: name, rst: 1'b1, default: '0};
    vecs.push_back(v);
  endtask

  // One row: a reset cycle, or an idle (inc low) cycle followed by a
  // rising inc_clk cycle with the row's load strobe.
  task automatic applyStimulus(input vec_t v);
    if (v.rst) begin
      reset = 1'b1; inc_clk = 1'b0; load = 1'b0;
      tick();
      reset = 1'b0;
      checkOutput(v.name, 8'd0, 1'b0, 1'b0);
      return;
    end
    dir = v.dir; mode = v.mode; limit = v.limit; load_val = v.loadVal;
    inc_clk = 1'b0; load = 1'b0;
    tick();
    checkOutput({v.name, "_idle"}, 8'(mCount), 1'b0, mDirOut[0]);
    inc_clk = 1'b1; load = v.load;
    tick();
    checkOutput(v.name, v.eCount, v.eTc, v.eDir);
    load = 1'b0;
  endtask

  initial begin
    int bncCount[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int satDown[6]  = '{4, 3, 2, 1, 0, 0};

    reset = 1'b1; inc_clk = 1'b1; dir = 1'b0; mode = 2'b00;
    limit = 8'd9; load = 1'b0; load_val = 8'd0;
    mCount = 0; mBounceDown = 0; mPrevInc = 1; mTc = 0; mDirOut = 0;

    // Reset with inc_clk high, then hold it high: no step may appear.
    tick(); tick();
    checkOutput("reset_state", 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("held_high", 8'd0, 1'b0, 1'b0);
    end
    inc_clk = 1'b0;
    tick();
    checkOutput("drop_inc", 8'd0, 1'b0, 1'b0);
    inc_clk = 1'b1;
    tick();
    checkOutput("first_rise", 8'd1, 1'b0, 1'b0);

    addReset("rst_wrap");
    for (int i = 1; i <= 10; i++)
      addVec("wrap_up", 1'b0, 2'b00, 8'd9, 1'b0, 8'd0, 8'(i % 10), i == 10, 1'b0);
    addVec("wrap_dn", 1'b1, 2'b00, 8'd9, 1'b0, 8'd0, 8'd9, 1'b1, 1'b1);

    addVec("sat_load", 1'b0, 2'b01, 8'd5, 1'b1, 8'd4, 8'd4, 1'b0, 1'b0);
    addVec("sat_up1", 1'b0, 2'b01, 8'd5, 1'b0, 8'd0, 8'd5, 1'b0, 1'b0);
    addVec("sat_up2", 1'b0, 2'b01, 8'd5, 1'b0, 8'd0, 8'd5, 1'b1, 1'b0);
    addVec("sat_up3", 1'b0, 2'b01, 8'd5, 1'b0, 8'd0, 8'd5, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      addVec("sat_dn", 1'b1, 2'b01, 8'd5, 1'b0, 8'd0, 8'(satDown[i]), i == 5, 1'b1);

    addVec("bnc_load", 1'b1, 2'b10, 8'd3, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      addVec("bounce", 1'b1, 2'b10, 8'd3, 1'b0, 8'd0, 8'(bncCount[i]),
             (i == 3) || (i == 6), (i >= 3) && (i <= 5));

    addVec("ld_conflict", 1'b0, 2'b00, 8'd50, 1'b1, 8'd200, 8'd50, 1'b0, 1'b0);
    addVec("ld_next", 1'b0, 2'b00, 8'd50, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);

    addVec("lim_load", 1'b0, 2'b01, 8'd20, 1'b1, 8'd15, 8'd15, 1'b0, 1'b0);
    addVec("lim_lowered", 1'b0, 2'b01, 8'd10, 1'b0, 8'd0, 8'd10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      addVec("lim_zero", 1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);

    addVec("hold_load", 1'b1, 2'b11, 8'd20, 1'b1, 8'd7, 8'd7, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      addVec("hold", 1'b1, 2'b11, 8'd20, 1'b0, 8'd0, 8'd7, 1'b0, 1'b1);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset while parked mid-count at 7.
    inc_clk = 1'b0; mode = 2'b00; dir = 1'b0;
    tick();
    checkOutput("pre_reset", 8'd7, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_reset", 8'd0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    limit = 8'd12;
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      inc_clk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)  dir = ~dir;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0)
        limit = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
      load     = ($urandom_range(0, 29) == 0);
      load_val = 8'($urandom_range(0, 20));
      tick();
      checkOutput("random", 8'(mCount), mTc[0], mDirOut[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
